// File: rtl/rvz_pkg.sv
// Shared definitions for the riscv_zero pipeline: controller state encoding,
// register address width and the opcodes decode uses to spot redirects and FENCE.
package rvz_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

endpackage

// File: rtl/rvz_hazard_ctrl_if.sv
// Decode / writeback / execute-redirect signals seen by the hazard controller,
// plus the issue, stall and flush controls it drives back.
interface rvz_hazard_ctrl_if;
   import rvz_pkg::*;

   logic                  dec_valid;
   logic [REG_ADDR_W-1:0] dec_rs1;
   logic [REG_ADDR_W-1:0] dec_rs2;
   logic                  dec_use_rs1;
   logic                  dec_use_rs2;
   logic [REG_ADDR_W-1:0] dec_rd;
   logic                  dec_wb_en;
   logic                  dec_fence;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  ex_redirect;
   logic                  issue;
   logic                  stall_fetch;
   logic                  stall_decode;
   logic                  flush_decode;
   logic                  flush_execute;

   modport master (
      output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
             dec_wb_en, dec_fence, wb_valid, wb_rd, ex_redirect,
      input  issue, stall_fetch, stall_decode, flush_decode, flush_execute
   );

   modport slave (
      input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
             dec_wb_en, dec_fence, wb_valid, wb_rd, ex_redirect,
      output issue, stall_fetch, stall_decode, flush_decode, flush_execute
   );

endinterface

// File: rtl/rvz_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never set.
// RVZ_HAZ_BYPASS_EN masks the register being written back out of busy_eff.
module rvz_scoreboard
   import rvz_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_idx,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_idx,
   output logic [NUM_REGS-1:0]   busy,
   output logic [NUM_REGS-1:0]   busy_eff
);

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   // NOTE: masks get a full default first so no path leaves them unassigned (no latch).
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && set_idx != '0) set_mask[set_idx] = 1'b1;
      if (clr_en && clr_idx != '0) clr_mask[clr_idx] = 1'b1;
   end

   // NOTE: non-blocking so every flop samples pre-edge values; OR-ing set last makes set win.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy <= '0;
      else       busy <= (busy & ~clr_mask) | set_mask;
   end

`ifdef RVZ_HAZ_BYPASS_EN
   assign busy_eff = busy & ~clr_mask;
`else
   assign busy_eff = busy;
`endif

endmodule

// File: rtl/rvz_hazard_ctrl.sv
// Issue/stall/flush sequencer beside decode: RAW/WAW stalls, redirect bubbles, FENCE drain.
// Optional RVZ_HAZ_BYPASS_EN lets a waiting instruction issue alongside its writeback.
module rvz_hazard_ctrl
   import rvz_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int NUM_REGS     = 32
) (
   input  logic                clk,
   input  logic                reset,
   rvz_hazard_ctrl_if.slave    bus,
   output logic [NUM_REGS-1:0] busy,
   output logic [1:0]          state
`ifdef RVZ_HAZ_BYPASS_EN
   ,
   output logic                fwd_rs1,
   output logic                fwd_rs2
`endif
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t              cur_state, nxt_state;
   logic [2:0]          cnt, cnt_nxt;
   logic [NUM_REGS-1:0] busy_eff;
   logic                haz;
   logic                issue, stall, flush_d, flush_e;

   rvz_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .set_en   (issue & bus.dec_wb_en),
      .set_idx  (bus.dec_rd),
      .clr_en   (bus.wb_valid),
      .clr_idx  (bus.wb_rd),
      .busy     (busy),
      .busy_eff (busy_eff)
   );

   // busy_eff[0] is structurally zero, so x0 can never raise a hazard.
   assign haz = (bus.dec_use_rs1 & busy_eff[bus.dec_rs1])
              | (bus.dec_use_rs2 & busy_eff[bus.dec_rs2])
              | (bus.dec_wb_en   & busy_eff[bus.dec_rd])
              | (bus.dec_fence   & (|busy_eff));

`ifdef RVZ_HAZ_BYPASS_EN
   assign fwd_rs1 = bus.dec_use_rs1 & bus.wb_valid & (bus.dec_rs1 == bus.wb_rd) & (bus.dec_rs1 != '0);
   assign fwd_rs2 = bus.dec_use_rs2 & bus.wb_valid & (bus.dec_rs2 == bus.wb_rd) & (bus.dec_rs2 != '0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= RUN;
         cnt       <= '0;
      end else begin
         cur_state <= nxt_state;
         cnt       <= cnt_nxt;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      cnt_nxt   = cnt;
      issue     = 1'b0;
      stall     = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      if (bus.ex_redirect) begin
         // A redirect overrides everything and restarts the bubble count from any state.
         flush_d   = 1'b1;
         flush_e   = 1'b1;
         cnt_nxt   = FLUSH_LOAD;
         nxt_state = FLUSH;
      end else begin
         unique case (cur_state)
            RUN: begin
               if (bus.dec_valid && bus.dec_fence && (|busy)) begin
                  stall     = 1'b1;
                  nxt_state = DRAIN;
               end else if (bus.dec_valid && haz) begin
                  stall = 1'b1;
               end else begin
                  issue = bus.dec_valid;
               end
            end
            FLUSH: begin
               flush_d = 1'b1;
               if (cnt == '0) nxt_state = RUN;
               else           cnt_nxt   = cnt - 3'd1;
            end
            DRAIN: begin
               stall = 1'b1;
               if (busy == '0) nxt_state = RUN;
            end
            default: nxt_state = RUN;
         endcase
      end
   end

   assign bus.issue         = issue;
   assign bus.stall_fetch   = stall;
   assign bus.stall_decode  = stall;
   assign bus.flush_decode  = flush_d;
   assign bus.flush_execute = flush_e;
   assign state             = cur_state;

endmodule
